path_query_driver: RTL and testbench

//  Initiator-side counterpart to the A* path-search controller (aStarCtrl mealy wrapper).

---
 rtl/path_pkg.sv | 20 ++
 rtl/path_query_driver_if.sv | 43 ++++
 rtl/path_node_buf.sv | 59 +++++
 rtl/path_query_driver.sv | 163 ++++++++++++++++
 tb/tb_path_query_driver.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/path_pkg.sv
// Shared types and constants for the path query driver and its node buffer.
package path_pkg;

    localparam int unsigned NODE_W = 16;
    localparam logic [NODE_W-1:0] COST_INF = 16'hFFFE;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_NOPATH   = 2'd1;
    localparam logic [1:0] ST_OVERFLOW = 2'd2;
    localparam logic [1:0] ST_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StCollect,
        StDrain,
        StDone
    } drv_state_e;

endpackage

// File: rtl/path_query_driver_if.sv
// Host, engine and status signals of the path query driver, grouped as one bus.
interface path_query_driver_if;

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [path_pkg::NODE_W-1:0] cmd_start;
    logic [path_pkg::NODE_W-1:0] cmd_goal;

    logic                        req_valid;
    logic                        req_ready;
    logic [path_pkg::NODE_W-1:0] req_start;
    logic [path_pkg::NODE_W-1:0] req_goal;

    logic                        rsp_valid;
    logic [path_pkg::NODE_W-1:0] rsp_node;
    logic                        rsp_last;
    logic                        rsp_fail;
    logic [path_pkg::NODE_W-1:0] rsp_cost;

    logic                        out_valid;
    logic                        out_ready;
    logic [path_pkg::NODE_W-1:0] out_node;
    logic                        out_last;

    logic                        status_valid;
    logic [1:0]                  status_code;
    logic [path_pkg::NODE_W-1:0] status_cost;

    modport slave (
        input  cmd_valid, cmd_start, cmd_goal, req_ready,
        input  rsp_valid, rsp_node, rsp_last, rsp_fail, rsp_cost, out_ready,
        output cmd_ready, req_valid, req_start, req_goal,
        output out_valid, out_node, out_last, status_valid, status_code, status_cost
    );

    modport master (
        output cmd_valid, cmd_start, cmd_goal, req_ready,
        output rsp_valid, rsp_node, rsp_last, rsp_fail, rsp_cost, out_ready,
        input  cmd_ready, req_valid, req_start, req_goal,
        input  out_valid, out_node, out_last, status_valid, status_code, status_cost
    );

endinterface

// File: rtl/path_node_buf.sv
// Path node buffer: DEPTH x NODE_W register file, one write port, one read port
// served straight from the registered array at the registered read pointer.
module path_node_buf import path_pkg::*; #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              system1000,
    input  logic              system1000_rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [NODE_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [NODE_W-1:0] rd_data,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty
);

    logic [NODE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              wr_ok, rd_ok;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (wr_ok && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/path_query_driver.sv
// Initiator-side driver for the A* path engine: takes one host query, requests a
// search, buffers the streamed path and replays it to the host, then reports status.
module path_query_driver import path_pkg::*; #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TMO_W = 12
) (
    input logic                 system1000,
    input logic                 system1000_rst,
    path_query_driver_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    drv_state_e        state_q;
    logic              cmd_ready_q, req_valid_q, out_valid_q, out_last_q, status_valid_q;
    logic [NODE_W-1:0] req_start_q, req_goal_q, cost_q, status_cost_q;
    logic [1:0]        status_code_q;
    logic              ovf_q;
    logic [TMO_W-1:0]  tmo_q;

    logic              accept, same_node, beat;
    logic              buf_wr, buf_rd, buf_flush, buf_full, buf_empty;
    logic [NODE_W-1:0] buf_wr_data, buf_rd_data;
    logic [PTR_W:0]    buf_count;

    always_comb begin
        accept      = (state_q == StIdle) && bus.cmd_valid && cmd_ready_q;
        same_node   = (bus.cmd_start == bus.cmd_goal);
        beat        = (state_q == StCollect) && bus.rsp_valid;
        buf_wr      = (accept && same_node) || (beat && !bus.rsp_fail);
        buf_wr_data = (state_q == StCollect) ? bus.rsp_node : bus.cmd_goal;
        buf_rd      = (state_q == StDrain) && out_valid_q && bus.out_ready && !buf_empty;
        buf_flush   = (state_q == StDone);
    end

    path_node_buf #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_buf (
        .system1000     (system1000),
        .system1000_rst (system1000_rst),
        .flush          (buf_flush),
        .wr_en          (buf_wr),
        .wr_data        (buf_wr_data),
        .rd_en          (buf_rd),
        .rd_data        (buf_rd_data),
        .count          (buf_count),
        .full           (buf_full),
        .empty          (buf_empty)
    );

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state_q        <= StIdle;
            cmd_ready_q    <= 1'b0;
            req_valid_q    <= 1'b0;
            req_start_q    <= '0;
            req_goal_q     <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            status_valid_q <= 1'b0;
            status_code_q  <= ST_OK;
            status_cost_q  <= COST_INF;
            cost_q         <= '0;
            ovf_q          <= 1'b0;
            tmo_q          <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        req_start_q <= bus.cmd_start;
                        req_goal_q  <= bus.cmd_goal;
                        ovf_q       <= 1'b0;
                        if (same_node) begin
                            // Trivial path: goal already sits in the buffer, no engine request.
                            cost_q      <= '0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b1;
                            state_q     <= StDrain;
                        end else begin
                            req_valid_q <= 1'b1;
                            state_q     <= StIssue;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                StIssue: begin
                    if (bus.req_ready) begin
                        req_valid_q <= 1'b0;
                        tmo_q       <= '0;
                        state_q     <= StCollect;
                    end
                end
                StCollect: begin
                    if (bus.rsp_valid) begin
                        tmo_q <= '0;
                        if (bus.rsp_fail) begin
                            status_valid_q <= 1'b1;
                            status_code_q  <= ST_NOPATH;
                            status_cost_q  <= COST_INF;
                            state_q        <= StDone;
                        end else if (bus.rsp_last) begin
                            if (ovf_q || buf_full) begin
                                status_valid_q <= 1'b1;
                                status_code_q  <= ST_OVERFLOW;
                                status_cost_q  <= COST_INF;
                                state_q        <= StDone;
                            end else begin
                                cost_q      <= bus.rsp_cost;
                                out_valid_q <= 1'b1;
                                out_last_q  <= (buf_count == '0);
                                state_q     <= StDrain;
                            end
                        end else if (buf_full) begin
                            ovf_q <= 1'b1;
                        end
                    end else if (tmo_q == '1) begin
                        status_valid_q <= 1'b1;
                        status_code_q  <= ST_TIMEOUT;
                        status_cost_q  <= COST_INF;
                        state_q        <= StDone;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                StDrain: begin
                    if (out_valid_q && bus.out_ready) begin
                        if (out_last_q) begin
                            out_valid_q    <= 1'b0;
                            out_last_q     <= 1'b0;
                            status_valid_q <= 1'b1;
                            status_code_q  <= ST_OK;
                            status_cost_q  <= cost_q;
                            state_q        <= StDone;
                        end else begin
                            out_last_q <= (buf_count == (PTR_W+1)'(2));
                        end
                    end
                end
                StDone: begin
                    status_valid_q <= 1'b0;
                    cmd_ready_q    <= 1'b1;
                    state_q        <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.req_valid    = req_valid_q;
    assign bus.req_start    = req_start_q;
    assign bus.req_goal     = req_goal_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_node     = buf_rd_data;
    assign bus.out_last     = out_last_q;
    assign bus.status_valid = status_valid_q;
    assign bus.status_code  = status_code_q;
    assign bus.status_cost  = status_cost_q;

endmodule

// File: tb/tb_path_query_driver.sv
// Directed bench for path_query_driver: normal, trivial, stalled, failing,
// overflowing and timed-out queries against hand-computed results.
module tb_path_query_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [15:0] got_node[$];
    logic        got_last[$];
    int          seen, n;

    always #5 clk = ~clk;

    path_query_driver_if bus ();

    path_query_driver #(
        .DEPTH (16),
        .TMO_W (12)
    ) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .bus            (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [15:0] s, input logic [15:0] g);
        bus.cmd_valid = 1'b1;
        bus.cmd_start = s;
        bus.cmd_goal  = g;
        for (int i = 0; i < 20 && !bus.cmd_ready; i++) tick();
        chk("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
    endtask

    task automatic rsp(input logic [15:0] node, input logic last, input logic fail,
                       input logic [15:0] cost);
        bus.rsp_valid = 1'b1;
        bus.rsp_node  = node;
        bus.rsp_last  = last;
        bus.rsp_fail  = fail;
        bus.rsp_cost  = cost;
        tick();
        bus.rsp_valid = 1'b0;
        bus.rsp_last  = 1'b0;
        bus.rsp_fail  = 1'b0;
    endtask

    task automatic collect_out(input int budget);
        got_node.delete();
        got_last.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (bus.out_valid) begin
                got_node.push_back(bus.out_node);
                got_last.push_back(bus.out_last);
            end
            tick();
            if (got_last.size() > 0 && got_last[$]) break;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic [1:0] code, input logic [15:0] cost);
        chk({tag, "_valid"}, {31'd0, bus.status_valid}, 32'd1);
        chk({tag, "_code"}, {30'd0, bus.status_code}, {30'd0, code});
        chk({tag, "_cost"}, {16'd0, bus.status_cost}, {16'd0, cost});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 0; bus.cmd_start = 0; bus.cmd_goal = 0; bus.req_ready = 0;
        bus.rsp_valid = 0; bus.rsp_node = 0; bus.rsp_last = 0; bus.rsp_fail = 0;
        bus.rsp_cost = 0; bus.out_ready = 0;

        // Reset state
        tick(); tick();
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        chk("rst_req_valid", {31'd0, bus.req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, bus.out_last}, 32'd0);
        chk("rst_status_valid", {31'd0, bus.status_valid}, 32'd0);
        chk("rst_status_code", {30'd0, bus.status_code}, 32'd0);
        chk("rst_status_cost", {16'd0, bus.status_cost}, 32'hFFFE);
        chk("rst_req_start", {16'd0, bus.req_start}, 32'd0);
        chk("rst_req_goal", {16'd0, bus.req_goal}, 32'd0);
        chk("rst_out_node", {16'd0, bus.out_node}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // Query 3 -> 9, engine returns 9,7,5,3 cost 12
        send_cmd(16'd3, 16'd9);
        chk("q1_req_valid", {31'd0, bus.req_valid}, 32'd1);
        chk("q1_req_start", {16'd0, bus.req_start}, 32'd3);
        chk("q1_req_goal", {16'd0, bus.req_goal}, 32'd9);
        chk("q1_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        handshake();
        chk("q1_req_drop", {31'd0, bus.req_valid}, 32'd0);
        rsp(16'd9, 1'b0, 1'b0, 16'd0);
        rsp(16'd7, 1'b0, 1'b0, 16'd0);
        rsp(16'd5, 1'b0, 1'b0, 16'd0);
        rsp(16'd3, 1'b1, 1'b0, 16'd12);
        chk("q1_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("q1_first_node", {16'd0, bus.out_node}, 32'd9);
        collect_out(20);
        chk("q1_beats", got_node.size(), 32'd4);
        chk("q1_n0", {16'd0, got_node[0]}, 32'd9);
        chk("q1_n1", {16'd0, got_node[1]}, 32'd7);
        chk("q1_n2", {16'd0, got_node[2]}, 32'd5);
        chk("q1_n3", {16'd0, got_node[3]}, 32'd3);
        chk("q1_last_early", {29'd0, got_last[0], got_last[1], got_last[2]}, 32'd0);
        chk("q1_last", {31'd0, got_last[3]}, 32'd1);
        chk_status("q1_status", 2'd0, 16'd12);
        tick();
        chk("q1_status_pulse", {31'd0, bus.status_valid}, 32'd0);

        // Query 5 -> 5: no engine request, single node
        send_cmd(16'd5, 16'd5);
        chk("q2_req_valid", {31'd0, bus.req_valid}, 32'd0);
        chk("q2_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("q2_out_last", {31'd0, bus.out_last}, 32'd1);
        seen = 0;
        got_node.delete();
        got_last.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_valid) seen++;
            if (bus.out_valid) begin
                got_node.push_back(bus.out_node);
                got_last.push_back(bus.out_last);
            end
            tick();
            if (got_last.size() > 0 && got_last[$]) break;
        end
        bus.out_ready = 1'b0;
        chk("q2_no_req", seen, 32'd0);
        chk("q2_beats", got_node.size(), 32'd1);
        chk("q2_node", {16'd0, got_node[0]}, 32'd5);
        chk_status("q2_status", 2'd0, 16'd0);
        tick();

        // Query 1 -> 2 with req_ready held low, then engine reports no path
        send_cmd(16'd1, 16'd2);
        for (int i = 0; i < 10; i++) begin
            chk("q3_hold_valid", {31'd0, bus.req_valid}, 32'd1);
            chk("q3_hold_start", {16'd0, bus.req_start}, 32'd1);
            chk("q3_hold_goal", {16'd0, bus.req_goal}, 32'd2);
            tick();
        end
        handshake();
        rsp(16'd0, 1'b0, 1'b1, 16'd0);
        chk_status("q3_status", 2'd1, 16'hFFFE);
        chk("q3_out_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        chk("q3_pulse_end", {31'd0, bus.status_valid}, 32'd0);
        chk("q3_code_held", {30'd0, bus.status_code}, 32'd1);

        // Query 10 -> 20, engine streams 20 beats into a 16-entry buffer
        send_cmd(16'd10, 16'd20);
        handshake();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) seen++;
            rsp(16'(100 + i), (i == 19), 1'b0, 16'd50);
        end
        chk("q4_no_out", seen, 32'd0);
        chk("q4_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk_status("q4_status", 2'd2, 16'hFFFE);
        tick();

        // Follow-up query must see a flushed buffer
        send_cmd(16'd2, 16'd8);
        handshake();
        rsp(16'd8, 1'b0, 1'b0, 16'd0);
        rsp(16'd2, 1'b1, 1'b0, 16'd4);
        collect_out(20);
        chk("q5_beats", got_node.size(), 32'd2);
        chk("q5_n0", {16'd0, got_node[0]}, 32'd8);
        chk("q5_n1", {16'd0, got_node[1]}, 32'd2);
        chk("q5_last", {30'd0, got_last[0], got_last[1]}, 32'd1);
        chk_status("q5_status", 2'd0, 16'd4);
        tick();

        // Query 1 -> 8, engine silent until timeout
        send_cmd(16'd1, 16'd8);
        handshake();
        n = 0;
        while (!bus.status_valid && n < 5000) begin
            tick();
            n++;
        end
        chk("q6_tmo_cycles", n, 32'd4096);
        chk_status("q6_status", 2'd3, 16'hFFFE);
        tick();

        // Late engine beat in idle is ignored; then a drain stalled by out_ready
        rsp(16'd77, 1'b1, 1'b0, 16'd99);
        chk("q7_idle_out", {31'd0, bus.out_valid}, 32'd0);
        send_cmd(16'd4, 16'd6);
        handshake();
        rsp(16'd6, 1'b0, 1'b0, 16'd0);
        rsp(16'd2, 1'b0, 1'b0, 16'd0);
        rsp(16'd4, 1'b1, 1'b0, 16'd7);
        for (int i = 0; i < 5; i++) begin
            chk("q7_stall_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("q7_stall_node", {16'd0, bus.out_node}, 32'd6);
            tick();
        end
        collect_out(20);
        chk("q7_beats", got_node.size(), 32'd3);
        chk("q7_n0", {16'd0, got_node[0]}, 32'd6);
        chk("q7_n1", {16'd0, got_node[1]}, 32'd2);
        chk("q7_n2", {16'd0, got_node[2]}, 32'd4);
        chk("q7_last", {29'd0, got_last[0], got_last[1], got_last[2]}, 32'd1);
        chk_status("q7_status", 2'd0, 16'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
